// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the unified memory arbiter: FSM states,
// owner encoding and default bus widths.
package riscv_mem_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } arb_state_e;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IF   = 2'b01;
  localparam logic [1:0] OWN_DM   = 2'b10;

endpackage

// File: rtl/mem_arb_streak_ctr.sv
// Saturating fairness counter: counts consecutive data grants made while a
// fetch is waiting, and forces the next grant to fetch once the limit is hit.
module mem_arb_streak_ctr
  import riscv_mem_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic grant_dm,
  input  logic grant_if,
  input  logic if_pending,
  output logic force_if
);

  logic [3:0] streak_q;

  // Count data grants that bypassed a pending fetch; any fetch grant or an
  // uncontested data grant restarts the streak.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      streak_q <= '0;
    end else if (grant_if || (grant_dm && !if_pending)) begin
      streak_q <= '0;
    end else if (grant_dm && (streak_q != 4'(MAX_DATA_STREAK))) begin
      streak_q <= streak_q + 4'd1;
    end
  end

  assign force_if = (streak_q == 4'(MAX_DATA_STREAK));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Unified memory arbiter: shares one memory port between instruction fetch
// (read-only) and data access (load/store). Data has priority, bounded by a
// streak counter so fetch always makes forward progress.
module unified_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int DATA_W          = DEF_DATA_W,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [3:0]        dm_be,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  arb_state_e state_q, state_d;
  logic       grant_if;
  logic       grant_dm;
  logic       force_if;
  logic       capture;

  mem_arb_streak_ctr #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_streak (
    .clk       (clk),
    .rst_n     (rst_n),
    .grant_dm  (grant_dm),
    .grant_if  (grant_if),
    .if_pending(if_req),
    .force_if  (force_if)
  );

  // Next-state and arbitration decode; grants only happen in IDLE.
  always_comb begin
    state_d  = state_q;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    capture  = 1'b0;
    case (state_q)
      IDLE: begin
        if (dm_req && !(if_req && force_if)) begin
          grant_dm = 1'b1;
        end else if (if_req) begin
          grant_if = 1'b1;
        end
        if (grant_dm || grant_if) state_d = REQ;
      end
      REQ: begin
        if (mem_gnt) begin
          if (mem_rvalid) begin
            capture = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Memory-side request registers: latch the winner, hold until accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      owner     <= OWN_NONE;
    end else begin
      if (grant_dm) begin
        owner     <= OWN_DM;
        mem_req   <= 1'b1;
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        mem_be    <= dm_be;
      end else if (grant_if) begin
        owner     <= OWN_IF;
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        mem_be    <= 4'hF;
      end else if ((state_q == REQ) && mem_gnt) begin
        mem_req   <= 1'b0;
      end
      if (state_q == RESP) owner <= OWN_NONE;
    end
  end

  // Requester-side responses: one-cycle valid in RESP, read data captured
  // into the owner's register; store acks leave read data untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      if_valid <= (state_d == RESP) && (owner == OWN_IF);
      dm_valid <= (state_d == RESP) && (owner == OWN_DM);
      if (capture && !mem_we) begin
        if (owner == OWN_IF) if_rdata <= mem_rdata;
        else                 dm_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one unified memory port between the pipeline's instruction-fetch requester (IF stage, read-only) and its data requester (MEM stage, loads and stores with byte enables).
- Sits between the CPU top and a single memory model. Replaces the split instruction/data memory hookup when the core runs against unified memory.
- Data has priority; a starvation counter guarantees fetch forward progress.
- Per-requester valid pulses let the top derive IF and MEM stall signals.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- MAX_DATA_STREAK, 4, maximum consecutive data grants while a fetch is pending (legal range 1..15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- if_req  in  1  fetch request; held until if_valid
- if_addr  in  ADDR_W  fetch address, word aligned
- if_rdata  out  DATA_W  fetched instruction
- if_valid  out  1  one-cycle fetch completion pulse
- dm_req  in  1  data request; held until dm_valid
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_be  in  4  byte enables
- dm_rdata  out  DATA_W  load data, raw 32-bit word
- dm_valid  out  1  one-cycle data completion pulse
- mem_req  out  1  request to memory; held until mem_gnt
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  4  memory byte enables
- mem_gnt  in  1  memory accepted the request this cycle
- mem_rvalid  in  1  read data valid, or write acknowledge
- mem_rdata  in  DATA_W  memory read data
- owner  out  2  debug: 00 none, 01 fetch, 10 data

Behaviour:
- One clock domain. Reset is synchronous on rst_n low.
  - State goes to IDLE; owner=00.
  - All outputs are 0, including the rdata registers.
  - Streak counter is 0.
- All outputs are registered.
- Requester contract:
  - req and its attributes stay stable from assertion until the cycle after valid.
  - The requester may drop req on the edge that ends the valid cycle.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - Samples if_req and dm_req and latches the winner's attributes into the mem_* registers.
  - Next state is REQ with mem_req=1.
  - With no request, stays in IDLE.
  - Any mem_gnt or mem_rvalid seen in IDLE is ignored.
- Arbitration when both requesters are pending:
  - Data wins unless streak == MAX_DATA_STREAK; then fetch wins.
- Streak counter:
  - Increments on each data grant made while if_req=1.
  - Clears on any fetch grant, and on a data grant made while if_req=0.
  - Saturates at MAX_DATA_STREAK.
- REQ:
  - mem_req stays 1 and attributes are stable until mem_gnt.
  - On mem_gnt: mem_req drops next cycle and the FSM goes to WAIT.
  - mem_gnt and mem_rvalid in the same cycle is legal: capture mem_rdata and go straight to RESP.
  - mem_rvalid without mem_gnt is ignored.
- WAIT:
  - On mem_rvalid, capture mem_rdata into the owner's rdata register and go to RESP.
  - Stores also wait for mem_rvalid (write ack); their rdata register is left unchanged.
- RESP:
  - Exactly one cycle. The owner's valid is 1; the other requester's valid is 0.
  - No arbitration takes place in RESP, so the same request cannot be re-issued.
  - Next state is IDLE; owner=00.
- Latency:
  - Request sampled in IDLE at cycle N.
  - mem_req visible at N+1.
  - With zero-wait memory (gnt and rvalid both at N+1), valid asserts at N+2.
- Throughput limit: at most one transaction per 3 cycles.
- Reset mid-transaction:
  - Abandons the transaction; no valid pulse is issued.
  - A late mem_rvalid after reset lands in IDLE and is ignored.
- No address-alignment checking; addresses and byte enables pass through unmodified.
- if_valid and dm_valid are never high in the same cycle.

Decomposition:
- Shared package riscv_mem_pkg holds:
  - the state enum (IDLE/REQ/WAIT/RESP);
  - the owner encoding constants (OWN_NONE/OWN_IF/OWN_DM);
  - the default ADDR_W/DATA_W.
- One sub-module: mem_arb_streak_ctr, the saturating fairness counter.
  - Inputs: grant_dm, grant_if, if_pending.
  - Output: force_if.
- FSM and datapath stay in the top module.

Test Plan:
- Fetch only, if_addr=0x00000010, zero-wait memory returning 0x00500093 -> mem_req at N+1 with mem_addr=0x10 and mem_we=0; if_valid with if_rdata=0x00500093 at N+2; owner back to 00.
- Store, dm_addr=0x8, dm_wdata=0xDEADBEEF, dm_be=4'b0011, mem_gnt delayed 2 cycles, ack 1 cycle later -> mem_req held 3 cycles with stable attributes; dm_valid pulses once; dm_rdata unchanged.
- if_req and dm_req held high continuously, MAX_DATA_STREAK=4 -> grant order D,D,D,D,I repeating; streak never exceeds 4.
- mem_gnt and mem_rvalid in the same cycle (rdata 0x12345678) on a load -> direct REQ to RESP; dm_valid=1 with dm_rdata=0x12345678 one cycle later.
- rst_n low for 1 cycle while in WAIT, then a stray mem_rvalid -> all outputs 0; no valid pulse; FSM stays IDLE.
- Requester keeps req high through the RESP cycle -> exactly one memory transaction per valid pulse; no duplicate mem_req.
